// File: rtl/cfg_pkg.sv
// rtl/cfg_pkg.sv - shared constants and types for the configuration write path
package cfg_pkg;

  localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [6:0] ADDR_DUTY      = 7'h04;

  localparam int CFG_NUM_REGS = 5;

  typedef struct packed {
    logic [6:0] addr;
    logic [7:0] data;
  } cfg_wr_req_t;

  // True when the address falls inside the decoded register window.
  function automatic logic addr_mapped(input logic [6:0] addr, input int unsigned num_regs);
    return 32'(addr) < num_regs;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter with accept-driven pointer
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] grant_o,
  output logic       last_grant_o
);

  logic last_grant_q;
  logic last_grant_d;

  // Single requester always wins; on a tie the port that did not win last time goes.
  always_comb begin
    grant_o = 2'b00;
    unique case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = last_grant_q ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

  // Pointer only moves when the granted request actually transferred.
  always_comb begin
    last_grant_d = last_grant_q;
    if (accept_i) begin
      if (grant_o[0]) begin
        last_grant_d = 1'b0;
      end else if (grant_o[1]) begin
        last_grant_d = 1'b1;
      end
    end
  end

  // Reset to 1 so port 0 takes the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  assign last_grant_o = last_grant_q;

endmodule

// File: rtl/cfg_write_arbiter.sv
// rtl/cfg_write_arbiter.sv - two-port config register file with period-aligned duty updates
module cfg_write_arbiter
  import cfg_pkg::*;
#(
  parameter int NUM_REGS  = CFG_NUM_REGS,
  parameter bit SYNC_DUTY = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s0_valid,
  input  logic [6:0] s0_addr,
  input  logic [7:0] s0_data,
  output logic       s0_ready,
  input  logic       s1_valid,
  input  logic [6:0] s1_addr,
  input  logic [7:0] s1_data,
  output logic       s1_ready,
  input  logic       pwm_period_start,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       duty_pending,
  output logic       wr_err
);

  logic [1:0]  grant;
  logic        last_grant;
  logic        wr_fire;
  logic        addr_ok;
  logic        duty_wr;
  logic        commit;
  cfg_wr_req_t wr_req;

  logic [7:0] en_out_lo_q, en_out_lo_d;
  logic [7:0] en_out_hi_q, en_out_hi_d;
  logic [7:0] en_pwm_lo_q, en_pwm_lo_d;
  logic [7:0] en_pwm_hi_q, en_pwm_hi_d;
  logic [7:0] duty_q, duty_d;
  logic [7:0] shadow_q, shadow_d;
  logic       pending_q, pending_d;
  logic       wr_err_q, wr_err_d;

  rr_arb2 u_arb (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_i        ({s1_valid, s0_valid}),
    .accept_i     (wr_fire),
    .grant_o      (grant),
    .last_grant_o (last_grant)
  );

  // Readies come straight from the grant, held low while reset is asserted.
  always_comb begin
    s0_ready = grant[0] & rst_n;
    s1_ready = grant[1] & rst_n;
    wr_fire  = s0_ready | s1_ready;
    wr_req   = s1_ready ? cfg_wr_req_t'{addr: s1_addr, data: s1_data}
                        : cfg_wr_req_t'{addr: s0_addr, data: s0_data};
    addr_ok  = addr_mapped(wr_req.addr, NUM_REGS);
  end

  // Decode the accepted write into the plain registers and flag unmapped addresses.
  always_comb begin
    en_out_lo_d = en_out_lo_q;
    en_out_hi_d = en_out_hi_q;
    en_pwm_lo_d = en_pwm_lo_q;
    en_pwm_hi_d = en_pwm_hi_q;
    duty_wr     = 1'b0;
    wr_err_d    = wr_fire & ~addr_ok;
    if (wr_fire && addr_ok) begin
      unique case (wr_req.addr)
        ADDR_EN_OUT_LO: en_out_lo_d = wr_req.data;
        ADDR_EN_OUT_HI: en_out_hi_d = wr_req.data;
        ADDR_EN_PWM_LO: en_pwm_lo_d = wr_req.data;
        ADDR_EN_PWM_HI: en_pwm_hi_d = wr_req.data;
        ADDR_DUTY:      duty_wr     = 1'b1;
        default:        duty_wr     = 1'b0;
      endcase
    end
  end

  // Duty path: either shadowed and committed on period start, or written through.
  // A commit and a new shadow load on the same edge both take effect: the old
  // shadow goes live and the new value waits for the following period.
  always_comb begin
    duty_d    = duty_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    commit    = 1'b0;
    if (SYNC_DUTY) begin
      commit = pwm_period_start & pending_q;
      if (commit) begin
        duty_d    = shadow_q;
        pending_d = 1'b0;
      end
      if (duty_wr) begin
        shadow_d  = wr_req.data;
        pending_d = 1'b1;
      end
    end else begin
      pending_d = 1'b0;
      if (duty_wr) begin
        duty_d = wr_req.data;
      end
    end
  end

  // State registers; reset discards any pending shadow value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_out_lo_q <= '0;
      en_out_hi_q <= '0;
      en_pwm_lo_q <= '0;
      en_pwm_hi_q <= '0;
      duty_q      <= '0;
      shadow_q    <= '0;
      pending_q   <= 1'b0;
      wr_err_q    <= 1'b0;
    end else begin
      en_out_lo_q <= en_out_lo_d;
      en_out_hi_q <= en_out_hi_d;
      en_pwm_lo_q <= en_pwm_lo_d;
      en_pwm_hi_q <= en_pwm_hi_d;
      duty_q      <= duty_d;
      shadow_q    <= shadow_d;
      pending_q   <= pending_d;
      wr_err_q    <= wr_err_d;
    end
  end

  assign en_reg_out_7_0  = en_out_lo_q;
  assign en_reg_out_15_8 = en_out_hi_q;
  assign en_reg_pwm_7_0  = en_pwm_lo_q;
  assign en_reg_pwm_15_8 = en_pwm_hi_q;
  assign pwm_duty_cycle  = duty_q;
  assign duty_pending    = pending_q;
  assign wr_err          = wr_err_q;

  logic unused_last_grant;
  assign unused_last_grant = last_grant;

endmodule

// File: tb/tb_cfg_write_arbiter.sv
// tb/tb_cfg_write_arbiter.sv - directed self-checking bench for cfg_write_arbiter
module tb_cfg_write_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s0_valid, s1_valid;
  logic [6:0] s0_addr, s1_addr;
  logic [7:0] s0_data, s1_data;
  logic       s0_ready, s1_ready;
  logic       pwm_period_start;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic       duty_pending, wr_err;

  int n_checks = 0;
  int n_fail   = 0;

  cfg_write_arbiter #(.NUM_REGS(5), .SYNC_DUTY(1'b1)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .s0_valid         (s0_valid),
    .s0_addr          (s0_addr),
    .s0_data          (s0_data),
    .s0_ready         (s0_ready),
    .s1_valid         (s1_valid),
    .s1_addr          (s1_addr),
    .s1_data          (s1_data),
    .s1_ready         (s1_ready),
    .pwm_period_start (pwm_period_start),
    .en_reg_out_7_0   (en_reg_out_7_0),
    .en_reg_out_15_8  (en_reg_out_15_8),
    .en_reg_pwm_7_0   (en_reg_pwm_7_0),
    .en_reg_pwm_15_8  (en_reg_pwm_15_8),
    .pwm_duty_cycle   (pwm_duty_cycle),
    .duty_pending     (duty_pending),
    .wr_err           (wr_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
  endtask

  task automatic write0(input logic [6:0] a, input logic [7:0] d, input logic pstart);
    s0_valid = 1'b1; s0_addr = a; s0_data = d; pwm_period_start = pstart;
    step();
    s0_valid = 1'b0; pwm_period_start = 1'b0;
  endtask

  task automatic period_pulse();
    pwm_period_start = 1'b1;
    step();
    pwm_period_start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    s0_valid = 1'b1; s1_valid = 1'b1;
    s0_addr = 7'h00; s1_addr = 7'h00; s0_data = 8'h00; s1_data = 8'h00;
    pwm_period_start = 1'b0;
    #3;
    n_checks++;
    if ({s0_ready, s1_ready} !== 2'b00) begin
      n_fail++; $display("FAIL reset_ready: got %b expected 00", {s0_ready, s1_ready});
    end
    n_checks++;
    if ({en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle, duty_pending, wr_err} !== 42'h0) begin
      n_fail++; $display("FAIL reset_outputs: got %h %h %h %h %h %b %b expected all zero",
        en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle, duty_pending, wr_err);
    end
    s0_valid = 1'b0; s1_valid = 1'b0;
    #9;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_write();
    s0_valid = 1'b1; s0_addr = 7'h00; s0_data = 8'hA5;
    #1;
    n_checks++;
    if ({s0_ready, s1_ready} !== 2'b10) begin
      n_fail++; $display("FAIL single_ready: got %b expected 10", {s0_ready, s1_ready});
    end
    n_checks++;
    if (en_reg_out_7_0 !== 8'h00) begin
      n_fail++; $display("FAIL single_pre: got %h expected 00", en_reg_out_7_0);
    end
    step();
    s0_valid = 1'b0;
    n_checks++;
    if (en_reg_out_7_0 !== 8'hA5) begin
      n_fail++; $display("FAIL single_data: got %h expected a5", en_reg_out_7_0);
    end
    n_checks++;
    if ({en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle, wr_err} !== 33'h0) begin
      n_fail++; $display("FAIL single_others: got %h %h %h %h %b expected zero",
        en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle, wr_err);
    end
    step();
    n_checks++;
    if (wr_err !== 1'b0) begin
      n_fail++; $display("FAIL single_wr_err: got %b expected 0", wr_err);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_rdy;
    logic [7:0] exp_val;
    do_reset();
    s0_valid = 1'b1; s0_addr = 7'h01; s0_data = 8'h11;
    s1_valid = 1'b1; s1_addr = 7'h01; s1_data = 8'h22;
    for (int i = 0; i < 3; i++) begin
      exp_rdy = (i % 2 == 0) ? 2'b10 : 2'b01;
      exp_val = (i % 2 == 0) ? 8'h11 : 8'h22;
      #1;
      n_checks++;
      if ({s0_ready, s1_ready} !== exp_rdy) begin
        n_fail++; $display("FAIL b2b_ready[%0d]: got %b expected %b", i, {s0_ready, s1_ready}, exp_rdy);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (en_reg_out_15_8 !== exp_val) begin
        n_fail++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, en_reg_out_15_8, exp_val);
      end
    end
    s0_valid = 1'b0; s1_valid = 1'b0;
  endtask

  task automatic test_bad_addr();
    s1_valid = 1'b1; s1_addr = 7'h05; s1_data = 8'hFF;
    #1;
    n_checks++;
    if ({s0_ready, s1_ready} !== 2'b01) begin
      n_fail++; $display("FAIL bad_ready: got %b expected 01", {s0_ready, s1_ready});
    end
    step();
    s1_valid = 1'b0;
    n_checks++;
    if (wr_err !== 1'b1) begin
      n_fail++; $display("FAIL bad_err_pulse: got %b expected 1", wr_err);
    end
    n_checks++;
    if ({en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle} !== 40'h00_11_00_00_00) begin
      n_fail++; $display("FAIL bad_regs: got %h %h %h %h %h expected 00 11 00 00 00",
        en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle);
    end
    step();
    n_checks++;
    if (wr_err !== 1'b0) begin
      n_fail++; $display("FAIL bad_err_clear: got %b expected 0", wr_err);
    end
    s1_valid = 1'b1; s1_addr = 7'h7F; s1_data = 8'h3C;
    step();
    s1_valid = 1'b0;
    n_checks++;
    if (wr_err !== 1'b1 || en_reg_out_15_8 !== 8'h11) begin
      n_fail++; $display("FAIL bad_addr7f: got err=%b r1=%h expected err=1 r1=11", wr_err, en_reg_out_15_8);
    end
    step();
  endtask

  task automatic test_pwm_regs();
    write0(7'h02, 8'h5C, 1'b0);
    write0(7'h03, 8'hC3, 1'b0);
    n_checks++;
    if ({en_reg_pwm_7_0, en_reg_pwm_15_8, wr_err} !== 17'h5C_C3 << 1) begin
      n_fail++; $display("FAIL pwm_regs: got %h %h err=%b expected 5c c3 err=0", en_reg_pwm_7_0, en_reg_pwm_15_8, wr_err);
    end
  endtask

  task automatic test_duty_sync();
    write0(7'h04, 8'h40, 1'b0);
    n_checks++;
    if (duty_pending !== 1'b1 || pwm_duty_cycle !== 8'h00) begin
      n_fail++; $display("FAIL duty_first: got pend=%b duty=%h expected pend=1 duty=00", duty_pending, pwm_duty_cycle);
    end
    write0(7'h04, 8'h80, 1'b0);
    step();
    n_checks++;
    if (duty_pending !== 1'b1 || pwm_duty_cycle !== 8'h00) begin
      n_fail++; $display("FAIL duty_second: got pend=%b duty=%h expected pend=1 duty=00", duty_pending, pwm_duty_cycle);
    end
    period_pulse();
    n_checks++;
    if (duty_pending !== 1'b0 || pwm_duty_cycle !== 8'h80) begin
      n_fail++; $display("FAIL duty_commit: got pend=%b duty=%h expected pend=0 duty=80", duty_pending, pwm_duty_cycle);
    end
    period_pulse();
    n_checks++;
    if (duty_pending !== 1'b0 || pwm_duty_cycle !== 8'h80) begin
      n_fail++; $display("FAIL duty_idle_period: got pend=%b duty=%h expected pend=0 duty=80", duty_pending, pwm_duty_cycle);
    end
  endtask

  task automatic test_duty_same_edge();
    write0(7'h04, 8'h30, 1'b0);
    write0(7'h04, 8'h90, 1'b1);
    n_checks++;
    if (duty_pending !== 1'b1 || pwm_duty_cycle !== 8'h30) begin
      n_fail++; $display("FAIL same_edge_commit: got pend=%b duty=%h expected pend=1 duty=30", duty_pending, pwm_duty_cycle);
    end
    period_pulse();
    n_checks++;
    if (duty_pending !== 1'b0 || pwm_duty_cycle !== 8'h90) begin
      n_fail++; $display("FAIL same_edge_next: got pend=%b duty=%h expected pend=0 duty=90", duty_pending, pwm_duty_cycle);
    end
    write0(7'h04, 8'h55, 1'b1);
    n_checks++;
    if (duty_pending !== 1'b1 || pwm_duty_cycle !== 8'h90) begin
      n_fail++; $display("FAIL same_edge_nopend: got pend=%b duty=%h expected pend=1 duty=90", duty_pending, pwm_duty_cycle);
    end
    period_pulse();
    n_checks++;
    if (duty_pending !== 1'b0 || pwm_duty_cycle !== 8'h55) begin
      n_fail++; $display("FAIL same_edge_late: got pend=%b duty=%h expected pend=0 duty=55", duty_pending, pwm_duty_cycle);
    end
  endtask

  task automatic test_reset_mid();
    write0(7'h04, 8'h77, 1'b0);
    s0_valid = 1'b1; s0_addr = 7'h00; s0_data = 8'h5A;
    s1_valid = 1'b1; s1_addr = 7'h00; s1_data = 8'h6B;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({s0_ready, s1_ready} !== 2'b00) begin
      n_fail++; $display("FAIL mid_reset_ready: got %b expected 00", {s0_ready, s1_ready});
    end
    n_checks++;
    if ({en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle, duty_pending, wr_err} !== 42'h0) begin
      n_fail++; $display("FAIL mid_reset_outputs: got %h %h %h %h %h %b %b expected all zero",
        en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle, duty_pending, wr_err);
    end
    step();
    rst_n = 1'b1;
    #1;
    n_checks++;
    if ({s0_ready, s1_ready} !== 2'b10) begin
      n_fail++; $display("FAIL mid_reset_tie: got %b expected 10", {s0_ready, s1_ready});
    end
    step();
    s0_valid = 1'b0; s1_valid = 1'b0;
    n_checks++;
    if (en_reg_out_7_0 !== 8'h5A) begin
      n_fail++; $display("FAIL mid_reset_write: got %h expected 5a", en_reg_out_7_0);
    end
    period_pulse();
    n_checks++;
    if (duty_pending !== 1'b0 || pwm_duty_cycle !== 8'h00) begin
      n_fail++; $display("FAIL mid_reset_discard: got pend=%b duty=%h expected pend=0 duty=00", duty_pending, pwm_duty_cycle);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_bad_addr();
    test_pwm_regs();
    test_duty_sync();
    test_duty_same_edge();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
